// File: rtl/uart_rx_deserializer_pkg.sv
// Shared constants, FSM encoding and PRESCALE legalisation for the UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_rx_deserializer_pkg;

   localparam int DATA_WD    = 8;
   localparam int PRESC_WD   = 6;
   localparam int BIT_CNT_WD = 4;

   localparam logic [PRESC_WD-1:0] PRESC_8  = PRESC_WD'(8);
   localparam logic [PRESC_WD-1:0] PRESC_16 = PRESC_WD'(16);
   localparam logic [PRESC_WD-1:0] PRESC_32 = PRESC_WD'(32);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   // Any ratio other than 16 or 32 falls back to the slowest-safe 8x oversampling.
   function automatic logic [PRESC_WD-1:0] legal_presc(input logic [PRESC_WD-1:0] p);
      return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
   endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Serial line, frame configuration and received-byte outputs of the UART receiver.
// Latency: n/a (signal bundle only).
// Backpressure: none; the byte side must accept data_vld whenever it pulses.
interface uart_rx_deserializer_if;
   import uart_rx_deserializer_pkg::*;

   logic                rx_in;
   logic                par_en;
   logic                par_typ;
   logic [PRESC_WD-1:0] prescale;
   logic [DATA_WD-1:0]  p_data;
   logic                data_vld;
   logic                par_err;
   logic                stp_err;
   logic                busy;

   modport master (
      output rx_in, par_en, par_typ, prescale,
      input  p_data, data_vld, par_err, stp_err, busy
   );

   modport slave (
      input  rx_in, par_en, par_typ, prescale,
      output p_data, data_vld, par_err, stp_err, busy
   );

endinterface

// File: rtl/uart_rx_deserializer_sampler.sv
// Per-bit edge counter, frame bit counter and 3-sample majority voter.
// Latency: bit_done asserts combinationally on edge P-1; sampled_bit is valid then.
// Backpressure: none; counting is free-running while the frame is active.
module uart_rx_deserializer_sampler
   import uart_rx_deserializer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  run,
   input  logic                  rx_in,
   input  logic [PRESC_WD-1:0]   presc,
   output logic                  sampled_bit,
   output logic                  bit_done,
   output logic [BIT_CNT_WD-1:0] bit_cnt
);

   logic [PRESC_WD-1:0] edge_cnt;
   logic [PRESC_WD-1:0] half;
   logic [PRESC_WD-1:0] presc_m1;
   logic [2:0]          samples;

   assign half        = presc >> 1;
   assign presc_m1    = presc - PRESC_WD'(1);
   assign bit_done    = run && (edge_cnt == presc_m1);
   assign sampled_bit = (samples[0] & samples[1]) |
                        (samples[0] & samples[2]) |
                        (samples[1] & samples[2]);

   // Edge/bit counting; the start-detect cycle was edge 0, so counting resumes at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
         samples  <= '0;
      end else if (start) begin
         edge_cnt <= PRESC_WD'(1);
         bit_cnt  <= '0;
      end else if (run) begin
         if (bit_done) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_CNT_WD'(1);
         end else begin
            edge_cnt <= edge_cnt + PRESC_WD'(1);
         end
         if (edge_cnt == half - PRESC_WD'(1)) samples[0] <= rx_in;
         if (edge_cnt == half)                samples[1] <= rx_in;
         if (edge_cnt == half + PRESC_WD'(1)) samples[2] <= rx_in;
      end else begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end
   end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start/data/parity/stop recovery with parity and stop checks.
// Latency: data_vld pulses (10 + par_en) * P clocks after the start edge is seen.
// Backpressure: none; a good byte is presented for one cycle and held in p_data.
module uart_rx_deserializer
   import uart_rx_deserializer_pkg::*;
(
   input logic                   clk,
   input logic                   rst,
   uart_rx_deserializer_if.slave rx_if
);

   rx_state_t             state;
   logic [PRESC_WD-1:0]   presc_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [DATA_WD-1:0]    shift_reg;
   logic                  err_par;
   logic [DATA_WD-1:0]    p_data_q;
   logic                  data_vld_q;
   logic                  par_err_q;
   logic                  stp_err_q;
   logic                  busy_q;
   logic                  start;
   logic                  run;
   logic                  sampled_bit;
   logic                  bit_done;
   logic [BIT_CNT_WD-1:0] bit_cnt;

   assign start = (state == ST_IDLE) && !rx_if.rx_in;
   assign run   = (state != ST_IDLE);

   uart_rx_deserializer_sampler u_sampler (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .run         (run),
      .rx_in       (rx_if.rx_in),
      .presc       (presc_q),
      .sampled_bit (sampled_bit),
      .bit_done    (bit_done),
      .bit_cnt     (bit_cnt)
   );

   // Frame FSM with shift register, parity check and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         presc_q    <= PRESC_8;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         shift_reg  <= '0;
         err_par    <= 1'b0;
         p_data_q   <= '0;
         data_vld_q <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         data_vld_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rx_if.rx_in) begin
                  state     <= ST_START;
                  busy_q    <= 1'b1;
                  presc_q   <= legal_presc(rx_if.prescale);
                  par_en_q  <= rx_if.par_en;
                  par_typ_q <= rx_if.par_typ;
                  err_par   <= 1'b0;
                  par_err_q <= 1'b0;
                  stp_err_q <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  if (sampled_bit) begin
                     // Start bit did not hold low through mid-bit: treat as a glitch.
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  shift_reg <= {sampled_bit, shift_reg[DATA_WD-1:1]};
                  // bit_cnt already counts the start bit, so DATA_WD marks the last data bit.
                  if (bit_cnt == BIT_CNT_WD'(DATA_WD)) begin
                     state <= par_en_q ? ST_PARITY : ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  err_par <= sampled_bit != (^shift_reg ^ par_typ_q);
                  state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  stp_err_q <= !sampled_bit;
                  par_err_q <= err_par;
                  if (sampled_bit && !err_par) begin
                     p_data_q   <= shift_reg;
                     data_vld_q <= 1'b1;
                  end
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign rx_if.p_data   = p_data_q;
   assign rx_if.data_vld = data_vld_q;
   assign rx_if.par_err  = par_err_q;
   assign rx_if.stp_err  = stp_err_q;
   assign rx_if.busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for the UART receiver with a scoreboard of expected bytes and arrival cycles.
// Latency: expects data_vld exactly (10 + par_en) * P clocks after the start bit is driven.
// Backpressure: n/a (bench always accepts).
module tb_uart_rx_deserializer;
   import uart_rx_deserializer_pkg::*;

   typedef struct {
      logic [7:0] d;
      int         t;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   uart_rx_deserializer_if dif ();

   uart_rx_deserializer dut (
      .clk   (clk),
      .rst   (rst),
      .rx_if (dif)
   );

   always #5 clk = ~clk;

   // Cycle count, read at negedges to time data_vld.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every data_vld pulse must match the oldest expected byte and cycle.
   always @(negedge clk) begin
      if (dif.data_vld === 1'b1) begin
         check("vld_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("p_data", 32'(dif.p_data), 32'(e.d));
            check("vld_cycle", 32'(cyc), 32'(e.t));
         end
      end
   end

   task automatic drive_bit(input logic b, input int p);
      dif.rx_in = b;
      repeat (p) @(negedge clk);
   endtask

   // Must be called at a negedge; a good frame is pushed to the scoreboard up front.
   task automatic send_frame(input logic [7:0] d, input int p, input bit pe,
                             input bit pb, input bit sb, input bit ok);
      if (ok) sb_q.push_back('{d: d, t: cyc + (pe ? 11 : 10) * p});
      drive_bit(1'b0, p);
      for (int i = 0; i < 8; i++) drive_bit(d[i], p);
      if (pe) drive_bit(pb, p);
      drive_bit(sb, p);
      dif.rx_in = 1'b1;
   endtask

   task automatic idle(input int n);
      dif.rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      dif.rx_in    = 1'b1;
      dif.par_en   = 1'b0;
      dif.par_typ  = 1'b0;
      dif.prescale = 6'd8;
      repeat (3) @(negedge clk);
      check("rst_p_data", 32'(dif.p_data), 32'h0);
      check("rst_data_vld", 32'(dif.data_vld), 32'h0);
      check("rst_par_err", 32'(dif.par_err), 32'h0);
      check("rst_stp_err", 32'(dif.stp_err), 32'h0);
      check("rst_busy", 32'(dif.busy), 32'h0);
      rst = 1'b0;
      idle(4);

      // 1: P=8, no parity, 0xA5.
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(10);
      check("t1_p_data_held", 32'(dif.p_data), 32'hA5);

      // 2: P=16, even parity, 0x0D good then bad parity.
      dif.prescale = 6'd16;
      dif.par_en   = 1'b1;
      dif.par_typ  = 1'b0;
      send_frame(8'h0D, 16, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(10);
      check("t2_par_err_good", 32'(dif.par_err), 32'h0);
      send_frame(8'h0D, 16, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(10);
      check("t2_par_err_bad", 32'(dif.par_err), 32'h1);
      check("t2_stp_err", 32'(dif.stp_err), 32'h0);
      check("t2_p_data_kept", 32'(dif.p_data), 32'h0D);

      // 3: P=32, odd parity, 0x3C with a bad stop bit.
      dif.prescale = 6'd32;
      dif.par_typ  = 1'b1;
      send_frame(8'h3C, 32, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(10);
      check("t3_stp_err", 32'(dif.stp_err), 32'h1);
      check("t3_par_err", 32'(dif.par_err), 32'h0);
      check("t3_p_data_kept", 32'(dif.p_data), 32'h0D);

      // 4: P=16, 3-clock low glitch.
      dif.prescale = 6'd16;
      dif.par_en   = 1'b0;
      dif.rx_in    = 1'b0;
      repeat (2) @(negedge clk);
      check("t4_busy_during", 32'(dif.busy), 32'h1);
      @(negedge clk);
      idle(24);
      check("t4_busy_after", 32'(dif.busy), 32'h0);
      check("t4_stp_err", 32'(dif.stp_err), 32'h0);
      check("t4_par_err", 32'(dif.par_err), 32'h0);

      // 5: P=8, back-to-back frames; scoreboard expects pulses 80 clocks apart.
      dif.prescale = 6'd8;
      send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(10);

      // Illegal prescale latches as 8; config changes mid-frame are ignored.
      dif.prescale = 6'd12;
      fork
         send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b1);
         begin
            repeat (20) @(negedge clk);
            dif.prescale = 6'd16;
            dif.par_en   = 1'b1;
         end
      join
      idle(10);
      check("cfg_par_err", 32'(dif.par_err), 32'h0);
      dif.prescale = 6'd8;
      dif.par_en   = 1'b0;

      // 6: reset during data bit 4, then a clean frame.
      drive_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) drive_bit(i[0], 8);
      dif.rx_in = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_p_data", 32'(dif.p_data), 32'h0);
      check("t6_rst_busy", 32'(dif.busy), 32'h0);
      check("t6_rst_vld", 32'(dif.data_vld), 32'h0);
      check("t6_rst_errs", 32'({dif.par_err, dif.stp_err}), 32'h0);
      rst = 1'b0;
      idle(10);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(20);
      check("t6_p_data", 32'(dif.p_data), 32'h5A);
      check("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
